sopc_bus_router: RTL and testbench

- Parametrised single-master, NUM_SLAVES-slave memory-mapped router between the CPU data/instruction bus and SOPC peripherals (SRAM, ROM, flash, serial, future devices).
- Replaces per-device hard-wired bus ports on the CPU top.
- Decodes each request by base/mask, forwards it to one slave with the address offset stripped, and returns data with a held ready.
- Adds an access timeout, an unmapped-address error, and a captured error address, none of which the current SOPC has.

---
 rtl/sopc_bus_router.sv | 230 +++++++++++++++++++++++
 tb/tb_sopc_bus_router.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sopc_bus_router.sv
// sopc_bus_router: single-master, NUM_SLAVES-slave memory-mapped bus router.
//
// Decodes each master request against per-slave base/mask pairs. The lowest
// slave index wins on overlap. The request is forwarded to one slave with the
// decoded base stripped from the address. The slave's read data is returned with
// a ready that is held until the master drops ce_i. Unmapped addresses and
// accesses that hit the timeout complete with err_o set, and the offending
// address is captured in err_addr_o.
//
// Ports:
//   clk, rst     bus clock; asynchronous active-high reset
//   ce_i         master request, held until ready_o is seen
//   we_i         1 = write, 0 = read
//   addr_i       master address
//   data_i       master write data
//   sel_i        master byte enables
//   data_o       read data to master (0 for writes and errors)
//   ready_o      transaction complete, held until ce_i falls
//   err_o        valid with ready_o; unmapped or timed out
//   err_addr_o   address of the most recent errored transaction
//   s_ce_o       one-hot slave chip enable
//   s_we_o       broadcast write enable
//   s_addr_o     address offset within the selected slave
//   s_data_o     broadcast write data
//   s_sel_o      broadcast byte enables
//   s_data_i     packed slave read data, slave 0 in the LSBs
//   s_ready_i    per-slave ready
module sopc_bus_router #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 32,
    parameter int unsigned TIMEOUT    = 255,
    parameter logic [NUM_SLAVES*AW-1:0] SLAVE_BASE =
        {32'hBFD003F8, 32'hBFC00000, 32'h1E000000, 32'h00000000},
    parameter logic [NUM_SLAVES*AW-1:0] SLAVE_MASK =
        {32'hFFFFFFF8, 32'hFFFFF000, 32'hFF000000, 32'hFF800000}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce_i,
    input  logic                     we_i,
    input  logic [AW-1:0]            addr_i,
    input  logic [DW-1:0]            data_i,
    input  logic [DW/8-1:0]          sel_i,
    output logic [DW-1:0]            data_o,
    output logic                     ready_o,
    output logic                     err_o,
    output logic [AW-1:0]            err_addr_o,
    output logic [NUM_SLAVES-1:0]    s_ce_o,
    output logic                     s_we_o,
    output logic [AW-1:0]            s_addr_o,
    output logic [DW-1:0]            s_data_o,
    output logic [DW/8-1:0]          s_sel_o,
    input  logic [NUM_SLAVES*DW-1:0] s_data_i,
    input  logic [NUM_SLAVES-1:0]    s_ready_i
);

    localparam int unsigned IdxW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value during the TIMEOUT-th ACCESS cycle.
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [DW-1:0]           data_q, data_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;
    logic [AW-1:0]           err_addr_q, err_addr_d;
    logic [NUM_SLAVES-1:0]   s_ce_q, s_ce_d;
    logic                    s_we_q, s_we_d;
    logic [AW-1:0]           s_addr_q, s_addr_d;
    logic [DW-1:0]           s_data_q, s_data_d;
    logic [DW/8-1:0]         s_sel_q, s_sel_d;

    // Address decode; the first matching slave from index 0 upward wins.
    logic                  hit;
    logic [IdxW-1:0]       hit_idx;
    logic [NUM_SLAVES-1:0] hit_onehot;
    logic [AW-1:0]         hit_offset;

    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        hit_onehot = '0;
        hit_offset = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (!hit && ((addr_i & SLAVE_MASK[k*AW +: AW]) == SLAVE_BASE[k*AW +: AW])) begin
                hit           = 1'b1;
                hit_idx       = IdxW'(k);
                hit_onehot[k] = 1'b1;
                hit_offset    = addr_i & ~SLAVE_MASK[k*AW +: AW];
            end
        end
    end

    // Only the latched slave's ready and read data are observed.
    logic          sel_ready;
    logic [DW-1:0] sel_rdata;

    assign sel_ready = s_ready_i[idx_q];
    assign sel_rdata = s_data_i[idx_q*DW +: DW];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ready_d    = ready_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        s_ce_d     = s_ce_q;
        s_we_d     = s_we_q;
        s_addr_d   = s_addr_q;
        s_data_d   = s_data_q;
        s_sel_d    = s_sel_q;

        unique case (state_q)
            StIdle: begin
                if (ce_i) begin
                    if (hit) begin
                        idx_d    = hit_idx;
                        addr_d   = addr_i;
                        cnt_d    = '0;
                        s_ce_d   = hit_onehot;
                        s_we_d   = we_i;
                        s_addr_d = hit_offset;
                        s_data_d = data_i;
                        s_sel_d  = sel_i;
                        state_d  = StAccess;
                    end else begin
                        ready_d    = 1'b1;
                        err_d      = 1'b1;
                        data_d     = '0;
                        err_addr_d = addr_i;
                        state_d    = StDone;
                    end
                end
            end

            StAccess: begin
                if (!ce_i) begin
                    // Master gave up: no ready pulse, a late slave ready is dropped.
                    s_ce_d  = '0;
                    state_d = StIdle;
                end else if (sel_ready) begin
                    s_ce_d  = '0;
                    ready_d = 1'b1;
                    err_d   = 1'b0;
                    data_d  = s_we_q ? '0 : sel_rdata;
                    state_d = StDone;
                end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
                    s_ce_d     = '0;
                    ready_d    = 1'b1;
                    err_d      = 1'b1;
                    data_d     = '0;
                    err_addr_d = addr_q;
                    state_d    = StDone;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StDone: begin
                // Response is held for slow masters until ce_i drops.
                if (!ce_i) begin
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                    data_d  = '0;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            s_ce_q     <= '0;
            s_we_q     <= 1'b0;
            s_addr_q   <= '0;
            s_data_q   <= '0;
            s_sel_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            s_ce_q     <= s_ce_d;
            s_we_q     <= s_we_d;
            s_addr_q   <= s_addr_d;
            s_data_q   <= s_data_d;
            s_sel_q    <= s_sel_d;
        end
    end

    assign data_o     = data_q;
    assign ready_o    = ready_q;
    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;
    assign s_ce_o     = s_ce_q;
    assign s_we_o     = s_we_q;
    assign s_addr_o   = s_addr_q;
    assign s_data_o   = s_data_q;
    assign s_sel_o    = s_sel_q;

endmodule

// File: tb/tb_sopc_bus_router.sv
// Bench for sopc_bus_router: hand-written vector table, abort/reset sequences,
// then randomized transactions checked against a rule-level reference model.
module tb_sopc_bus_router;

    localparam int NS = 4;
    localparam int TO = 4;

    localparam logic [31:0] BASE_ARR [NS] =
        '{32'h00000000, 32'h1E000000, 32'hBFC00000, 32'hBFD003F8};
    localparam logic [31:0] MASK_ARR [NS] =
        '{32'hFF800000, 32'hFF000000, 32'hFFFFF000, 32'hFFFFFFF8};

    logic          clk;
    logic          rst;
    logic          ce_i;
    logic          we_i;
    logic [31:0]   addr_i;
    logic [31:0]   data_i;
    logic [3:0]    sel_i;
    logic [31:0]   data_o;
    logic          ready_o;
    logic          err_o;
    logic [31:0]   err_addr_o;
    logic [NS-1:0] s_ce_o;
    logic          s_we_o;
    logic [31:0]   s_addr_o;
    logic [31:0]   s_data_o;
    logic [3:0]    s_sel_o;
    logic [127:0]  s_data_i;
    logic [NS-1:0] s_ready_i;

    sopc_bus_router #(
        .NUM_SLAVES (NS),
        .DW         (32),
        .AW         (32),
        .TIMEOUT    (TO),
        .SLAVE_BASE ({32'hBFD003F8, 32'hBFC00000, 32'h1E000000, 32'h00000000}),
        .SLAVE_MASK ({32'hFFFFFFF8, 32'hFFFFF000, 32'hFF000000, 32'hFF800000})
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .sel_i      (sel_i),
        .data_o     (data_o),
        .ready_o    (ready_o),
        .err_o      (err_o),
        .err_addr_o (err_addr_o),
        .s_ce_o     (s_ce_o),
        .s_we_o     (s_we_o),
        .s_addr_o   (s_addr_o),
        .s_data_o   (s_data_o),
        .s_sel_o    (s_sel_o),
        .s_data_i   (s_data_i),
        .s_ready_i  (s_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_err_addr = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // First matching slave, scanning from index 0.
    function automatic void model_decode(input logic [31:0] a, output bit hit, output int idx);
        hit = 1'b0;
        idx = 0;
        for (int k = 0; k < NS; k++) begin
            if (!hit && ((a & MASK_ARR[k]) == BASE_ARR[k])) begin
                hit = 1'b1;
                idx = k;
            end
        end
    endfunction

    // Called at a negedge. lat = ACCESS cycle in which the slave raises ready
    // (0 or > TO means never). hold = extra cycles ce_i stays high after ready_o.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] sel, input int lat, input logic [31:0] rd,
                           input int hold, output logic o_err, output logic [31:0] o_data,
                           output logic [3:0] o_ce, output logic [31:0] o_saddr);
        bit          hit;
        int          idx;
        bit          exp_err;
        logic [31:0] exp_data;
        logic [3:0]  smask;
        model_decode(addr, hit, idx);
        smask   = hit ? (4'b0001 << idx) : 4'b0000;
        o_ce    = '0;
        o_saddr = '0;
        for (int k = 0; k < NS; k++) s_data_i[k*32 +: 32] = $urandom;
        if (hit) s_data_i[idx*32 +: 32] = rd;
        s_ready_i = 4'($urandom) & ~smask;
        ce_i   = 1'b1;
        we_i   = we;
        addr_i = addr;
        data_i = wd;
        sel_i  = sel;
        if (hit) begin
            for (int c = 1; c <= TO; c++) begin
                @(negedge clk);
                chk("acc_s_ce", s_ce_o, smask);
                chk("acc_s_addr", s_addr_o, addr & ~MASK_ARR[idx]);
                chk("acc_s_we", s_we_o, we);
                chk("acc_s_data", s_data_o, wd);
                chk("acc_s_sel", s_sel_o, sel);
                chk("acc_ready", ready_o, 1'b0);
                if (c == 1) o_saddr = s_addr_o;
                o_ce = o_ce | s_ce_o;
                s_ready_i = 4'($urandom) & ~smask;
                if (c == lat) begin
                    s_ready_i = s_ready_i | smask;
                    break;
                end
            end
            exp_err  = !(lat >= 1 && lat <= TO);
            exp_data = (exp_err || we) ? 32'h0 : rd;
        end else begin
            exp_err  = 1'b1;
            exp_data = 32'h0;
        end
        if (exp_err) exp_err_addr = addr;
        @(negedge clk);
        s_ready_i = 4'($urandom) & ~smask;
        o_ce   = o_ce | s_ce_o;
        o_err  = err_o;
        o_data = data_o;
        chk("done_ready", ready_o, 1'b1);
        chk("done_err", err_o, exp_err);
        chk("done_data", data_o, exp_data);
        chk("done_s_ce", s_ce_o, 4'b0000);
        chk("done_err_addr", err_addr_o, exp_err_addr);
        for (int h = 0; h < hold; h++) begin
            addr_i = $urandom;
            @(negedge clk);
            o_ce = o_ce | s_ce_o;
            chk("hold_ready", ready_o, 1'b1);
            chk("hold_err", err_o, exp_err);
            chk("hold_data", data_o, exp_data);
            chk("hold_s_ce", s_ce_o, 4'b0000);
        end
        ce_i = 1'b0;
        @(negedge clk);
        chk("clr_ready", ready_o, 1'b0);
        chk("clr_err", err_o, 1'b0);
        chk("clr_data", data_o, 32'h0);
        chk("clr_s_ce", s_ce_o, 4'b0000);
        chk("clr_err_addr", err_addr_o, exp_err_addr);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  sel;
        int          lat;
        logic [31:0] rd;
        logic        exp_err;
        logic [31:0] exp_data;
        logic [3:0]  exp_ce;
        logic [31:0] exp_saddr;
    } vec_t;

    vec_t vecs [9];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic        r_err;
        logic [31:0] r_data;
        logic [3:0]  r_ce;
        logic [31:0] r_saddr;

        vecs[0] = '{1'b0, 32'h00000010, 32'h0, 4'hF, 3, 32'h12345678,
                    1'b0, 32'h12345678, 4'b0001, 32'h10};
        vecs[1] = '{1'b1, 32'hBFD003F8, 32'h41, 4'b0001, 1, 32'hDEADBEEF,
                    1'b0, 32'h0, 4'b1000, 32'h0};
        vecs[2] = '{1'b0, 32'h80000000, 32'h0, 4'hF, 1, 32'h0,
                    1'b1, 32'h0, 4'b0000, 32'h0};
        vecs[3] = '{1'b0, 32'h1E000100, 32'h0, 4'hF, 0, 32'h11111111,
                    1'b1, 32'h0, 4'b0010, 32'h100};
        vecs[4] = '{1'b0, 32'h1E000100, 32'h0, 4'hF, 4, 32'hAABBCCDD,
                    1'b0, 32'hAABBCCDD, 4'b0010, 32'h100};
        vecs[5] = '{1'b0, 32'hBFC00ABC, 32'h0, 4'hF, 1, 32'h55AA55AA,
                    1'b0, 32'h55AA55AA, 4'b0100, 32'hABC};
        vecs[6] = '{1'b0, 32'hBFD003FC, 32'h0, 4'hF, 2, 32'hCAFEF00D,
                    1'b0, 32'hCAFEF00D, 4'b1000, 32'h4};
        vecs[7] = '{1'b0, 32'hBFD00400, 32'h0, 4'hF, 1, 32'h0,
                    1'b1, 32'h0, 4'b0000, 32'h0};
        vecs[8] = '{1'b1, 32'h1E00FFF0, 32'h87654321, 4'b1100, 4, 32'h0,
                    1'b0, 32'h0, 4'b0010, 32'hFFF0};

        rst       = 1'b1;
        ce_i      = 1'b0;
        we_i      = 1'b0;
        addr_i    = '0;
        data_i    = '0;
        sel_i     = '0;
        s_data_i  = '0;
        s_ready_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_err_addr", err_addr_o, 32'h0);
        chk("rst_s_ce", s_ce_o, 4'b0000);
        chk("rst_s_we", s_we_o, 1'b0);
        chk("rst_s_addr", s_addr_o, 32'h0);
        chk("rst_s_data", s_data_o, 32'h0);
        chk("rst_s_sel", s_sel_o, 4'h0);
        rst = 1'b0;
        @(negedge clk);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].sel, vecs[i].lat,
                    vecs[i].rd, 2, r_err, r_data, r_ce, r_saddr);
            chk($sformatf("vec%0d_err", i), r_err, vecs[i].exp_err);
            chk($sformatf("vec%0d_data", i), r_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_ce", i), r_ce, vecs[i].exp_ce);
            if (vecs[i].exp_ce != 4'b0000)
                chk($sformatf("vec%0d_saddr", i), r_saddr, vecs[i].exp_saddr);
        end

        // Abort in ACCESS; the slave's late ready must not produce ready_o.
        s_ready_i = '0;
        ce_i   = 1'b1;
        we_i   = 1'b0;
        addr_i = 32'h1E000200;
        @(negedge clk);
        chk("abort_s_ce_on", s_ce_o, 4'b0010);
        ce_i = 1'b0;
        @(negedge clk);
        chk("abort_s_ce_off", s_ce_o, 4'b0000);
        chk("abort_ready", ready_o, 1'b0);
        @(negedge clk);
        s_ready_i = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_late_ready", ready_o, 1'b0);
            chk("abort_late_s_ce", s_ce_o, 4'b0000);
        end
        s_ready_i = '0;
        run_txn(1'b0, 32'hBFC00010, 32'h0, 4'hF, 2, 32'h0BADCAFE, 1,
                r_err, r_data, r_ce, r_saddr);
        chk("post_abort_err", r_err, 1'b0);
        chk("post_abort_data", r_data, 32'h0BADCAFE);

        // Async reset mid-ACCESS, with a non-zero captured error address.
        run_txn(1'b0, 32'h80000000, 32'h0, 4'hF, 1, 32'h0, 0, r_err, r_data, r_ce, r_saddr);
        chk("pre_rst_err_addr", err_addr_o, 32'h80000000);
        ce_i   = 1'b1;
        we_i   = 1'b0;
        addr_i = 32'h00000020;
        @(negedge clk);
        chk("pre_rst_s_ce", s_ce_o, 4'b0001);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_s_ce", s_ce_o, 4'b0000);
        chk("async_rst_ready", ready_o, 1'b0);
        chk("async_rst_err", err_o, 1'b0);
        chk("async_rst_err_addr", err_addr_o, 32'h0);
        exp_err_addr = 32'h0;
        ce_i = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle_s_ce", s_ce_o, 4'b0000);
        run_txn(1'b0, 32'h00000020, 32'h0, 4'hF, 1, 32'h13579BDF, 0,
                r_err, r_data, r_ce, r_saddr);
        chk("post_rst_err", r_err, 1'b0);
        chk("post_rst_data", r_data, 32'h13579BDF);

        // Randomized transactions; expectations come from model_decode inside run_txn.
        for (int n = 0; n < 150; n++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 4);
            if (kind < NS) a = BASE_ARR[kind] | ($urandom & ~MASK_ARR[kind]);
            else a = $urandom;
            run_txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 6), $urandom,
                    $urandom_range(0, 3), r_err, r_data, r_ce, r_saddr);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
